// File: rtl/seg7_scan_pkg.sv
// Shared constants and FSM state type for the seven-segment digit scanner.
package seg7_scan_pkg;

  localparam int SEG7_NDIG     = 8;
  localparam int SEG7_SLOT_CYC = 50000;
  localparam int SEG7_DEAD_CYC = 16;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } seg7_state_e;

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot/digit timer for seg7_scan: cnt runs 0..SLOT_CYC-1 per digit, idx walks the digits.
//   state    | meaning
//   ST_BLANK | first DEAD_CYC cycles of a slot, all anodes off
//   ST_SHOW  | remainder of the slot, current digit enabled
module seg7_slot_timer
  import seg7_scan_pkg::*;
#(
  parameter int NDIG     = SEG7_NDIG,
  parameter int SLOT_CYC = SEG7_SLOT_CYC,
  parameter int DEAD_CYC = SEG7_DEAD_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [2:0]  idx_o,
  output logic        slot_wrap_o,
  output logic        frame_wrap_o,
  output seg7_state_e state_o
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
  localparam logic [2:0]    IDX_LAST = 3'(NDIG - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  seg7_state_e   state_q, state_d;
  logic          slot_wrap, frame_wrap;

  assign slot_wrap  = (cnt_q == CNT_LAST);
  assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = slot_wrap ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_wrap) idx_d = frame_wrap ? 3'd0 : idx_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      state_q <= ST_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  // With DEAD_CYC==0 there is no blank window, so SHOW persists across slot wraps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d == CNT_DEAD) state_d = ST_SHOW;
      ST_SHOW:  if (slot_wrap && (DEAD_CYC != 0)) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  always_comb begin
    idx_o        = idx_q;
    state_o      = state_q;
    slot_wrap_o  = slot_wrap;
    frame_wrap_o = frame_wrap;
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed hex display scanner: shadow/display registers and registered digit outputs.
// Define SEG7_LZB_EN to compile in leading-zero blanking of the anode enables.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int NDIG     = SEG7_NDIG,
  parameter int SLOT_CYC = SEG7_SLOT_CYC,
  parameter int DEAD_CYC = SEG7_DEAD_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_i,
  input  logic        load_i,
  output logic [3:0]  dig_o,
  output logic [7:0]  an_o,
  output logic        frame_o
);

  logic [31:0] shadow_q, shadow_d;
  logic [31:0] disp_q, disp_d;
  logic [3:0]  dig_q, dig_d;
  logic [7:0]  an_q, an_d;
  logic        frame_q, frame_d;

  logic [2:0]  idx;
  logic        slot_wrap_unused;
  logic        frame_wrap;
  seg7_state_e state;
  logic [7:0]  digit_en;

  seg7_slot_timer #(
    .NDIG     (NDIG),
    .SLOT_CYC (SLOT_CYC),
    .DEAD_CYC (DEAD_CYC)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .idx_o        (idx),
    .slot_wrap_o  (slot_wrap_unused),
    .frame_wrap_o (frame_wrap),
    .state_o      (state)
  );

`ifdef SEG7_LZB_EN
  // Enable every digit up to the most significant nonzero nibble; digit 0 always on.
  always_comb begin
    digit_en = 8'h01;
    for (int k = 1; k < NDIG; k++) begin
      if (disp_q[4*k +: 4] != 4'h0) digit_en = 8'((1 << (k + 1)) - 1);
    end
  end
`else
  assign digit_en = 8'hFF;
`endif

  // disp only reloads on the frame wrap so a frame never mixes two values.
  always_comb begin
    shadow_d = load_i ? data_i : shadow_q;
    disp_d   = frame_wrap ? shadow_q : disp_q;
  end

  always_comb begin
    an_d    = 8'hFF;
    if ((state == ST_SHOW) && digit_en[idx]) an_d[idx] = 1'b0;
    dig_d   = disp_q[{idx, 2'b00} +: 4];
    frame_d = frame_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      disp_q   <= '0;
      dig_q    <= 4'h0;
      an_q     <= 8'hFF;
      frame_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      dig_q    <= dig_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
    end
  end

  assign dig_o   = dig_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule
